uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter WordLength, default 8, data bits per frame (legal 5..8).
REQ-002 Parameter StopBitTicks, default 16, sample ticks spanned by the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_i  input  1  serial line, idle high, asynchronous to clk.
REQ-006 tick_i  input  1  oversampling strobe, one clk wide, 16 per bit period.
REQ-007 dout_o  output  8  received word, LSB-first assembled, right-justified, unused MSBs zero.
REQ-008 eorx_o  output  1  end-of-receive, one-clk pulse when dout_o/status update.
REQ-009 frame_err_o  output  1  stop bit sampled low on the last frame.
REQ-010 parity_err_o  output  1  parity mismatch on the last frame (see Configuration).
REQ-011 busy_o  output  1  high whenever the FSM is not in idle.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer (both flops reset to 1); all FSM decisions use the synchronized value rx_s.
REQ-013 The FSM SHALL have states idle, start, data, parity (macro only), stop; sample counter s is 4 bits, bit counter n is 3 bits, shift buffer b is 8 bits.
REQ-014 idle: tick_i ignored; on rx_s==0 -> start, s=0.
REQ-015 start: on tick_i, if s==7 then rx_s==0 -> data with s=0, n=0; rx_s==1 -> idle (glitch rejected, no eorx_o); else s=s+1.
REQ-016 data: on tick_i, if s==15 then s=0, b={rx_s, b[7:1]}; if n==WordLength-1 -> parity (macro) or stop, else n=n+1; else s=s+1.
REQ-017 stop: on tick_i, if s==StopBitTicks-1 then -> idle and register outputs per REQ-018; else s=s+1 (s widened if StopBitTicks>16).
REQ-018 On stop exit, at the next clk edge: dout_o = b >> (8-WordLength); frame_err_o = ~rx_s; parity_err_o per REQ-026; eorx_o = 1 for exactly one clk.
REQ-019 dout_o, frame_err_o, parity_err_o SHALL hold their values until the next eorx_o; a frame with frame_err_o=1 still reports eorx_o and dout_o.
REQ-020 A new start bit SHALL be accepted in the clk cycle after returning to idle (back-to-back frames, no dead time beyond the stop bit).
REQ-021 Cycles with tick_i=0 SHALL leave s, n, b and state unchanged except idle->start detection.
REQ-022 busy_o SHALL be combinationally (state != idle).

Reset
REQ-023 On rst: state=idle, s=0, n=0, b=0, sync flops=1, dout_o=0, eorx_o=0, frame_err_o=0, parity_err_o=0, busy_o=0.
REQ-024 rst asserted mid-frame SHALL abort the frame with no eorx_o and no update of dout_o/status; reception restarts on the next falling edge after rst deasserts.

Configuration
REQ-025 Macro UART_RX_PARITY_EN SHALL compile in an even-parity bit after the last data bit.
REQ-026 With the macro: parity state samples rx_s on tick_i at s==15 (s=0 -> stop); parity_err_o = XOR(data bits) ^ sampled bit. Without it: no parity state, data goes directly to stop, parity_err_o tied 0, port still present.

Verification
REQ-027 Frame 0xA5, 16 ticks/bit, valid stop -> one eorx_o pulse, dout_o=0xA5, frame_err_o=0, busy_o low after.
REQ-028 rx_i low for 4 ticks then high -> back to idle, no eorx_o, dout_o keeps previous value.
REQ-029 Frame 0x3C with stop bit driven 0 -> eorx_o, dout_o=0x3C, frame_err_o=1; next clean 0x55 frame clears frame_err_o.
REQ-030 Back-to-back 0x00 then 0xFF with no idle gap -> two eorx_o pulses, dout_o 0x00 then 0xFF.
REQ-031 rst asserted at data bit 4 of 0x81 -> no eorx_o, all outputs 0; following 0x42 received correctly.
REQ-032 UART_RX_PARITY_EN defined: 0x01 with parity bit 0 -> parity_err_o=1; 0x01 with parity bit 1 -> parity_err_o=0.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-flop input synchronizer, mid-bit sampling.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int WordLength   = 8,
  parameter int StopBitTicks = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  input  logic       tick_i,
  output logic [7:0] dout_o,
  output logic       eorx_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       busy_o,
  output logic [2:0] state_dbg
);

  // The sample counter grows past 4 bits only for stop bits longer than one bit time.
  localparam int SW = (StopBitTicks > 16) ? $clog2(StopBitTicks) : 4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_LAST = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(StopBitTicks - 1);
  localparam logic [2:0]    N_LAST = 3'(WordLength - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] s, s_nxt;
  logic [2:0]    n, n_nxt;
  logic [7:0]    b, b_nxt;
  logic          rx_meta, rx_s;
  logic          done;
  logic [7:0]    word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
      b     <= b_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_bit <= 1'b0;
    else     par_bit <= par_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
    done      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          s_nxt     = '0;
        end
      end
      START: begin
        if (tick_i) begin
          if (s == S_MID) begin
            // Start bit must still be low at its midpoint, otherwise it was a glitch.
            if (!rx_s) begin
              state_nxt = DATA;
              s_nxt     = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick_i) begin
          if (s == S_LAST) begin
            s_nxt = '0;
            b_nxt = {rx_s, b[7:1]};
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_i) begin
          if (s == S_LAST) begin
            par_nxt   = rx_s;
            s_nxt     = '0;
            state_nxt = STOP;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick_i) begin
          // Leaving at mid-stop lets a following start bit be caught with no dead time.
          if (s == S_STOP) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data bits arrive LSB first into the top of b; right-justify them.
  assign word = b >> (8 - WordLength);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_o      <= '0;
      eorx_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      eorx_o <= done;
      if (done) begin
        dout_o      <= word;
        frame_err_o <= ~rx_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       parity_err_o <= 1'b0;
    else if (done) parity_err_o <= (^word) ^ par_bit;
  end
`else
  assign parity_err_o = 1'b0;
`endif

  assign busy_o    = (state != IDLE);
  assign state_dbg = state;

endmodule
